// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to
// instruction memory, and buffers in-order responses in a small FIFO.
// Decode sees the FIFO head via a valid/ready handshake. A redirect
// flushes the FIFO and marks every request still in flight as stale.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode
);

  localparam int unsigned     PW      = $clog2(BUF_DEPTH);
  // Counters must hold sums of two full-depth quantities.
  localparam int unsigned     CW      = PW + 2;
  localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_M = ~(XLEN'(3));

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] buf_data [BUF_DEPTH];
  logic [XLEN-1:0] buf_pc   [BUF_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   live_cnt;   // accepted, current-path, not yet answered
  logic [CW-1:0]   drop_cnt;   // accepted, stale-path, not yet answered

  logic            pop;
  logic            push;
  logic            req_fire;
  logic            resp_live;
  logic            resp_drop;
  logic            fifo_full;
  logic [CW-1:0]   credit_use;
  logic [CW-1:0]   inflight;
  logic [XLEN-1:0] redirect_base;

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = (fifo_count != '0);
  assign inst_data     = buf_data[rd_ptr];
  assign inst_pc       = buf_pc[rd_ptr];
  assign opcode        = inst_data[6:0];

  // Handshake qualification and request credit check.
  always_comb begin
    pop        = inst_valid & inst_ready;
    fifo_full  = (fifo_count == DEPTH_C);
    // A word popped this cycle frees its slot for a request issued now.
    credit_use = fifo_count + live_cnt - CW'(pop);
    inflight   = drop_cnt + live_cnt;
    imem_req_valid = ~rst & (credit_use < DEPTH_C) & (inflight < DEPTH_C);
    req_fire   = imem_req_valid & imem_req_ready;
    resp_live  = imem_resp_valid & (drop_cnt == '0);
    resp_drop  = imem_resp_valid & (drop_cnt != '0);
    // A response landing in the redirect cycle belongs to the old path.
    push       = resp_live & ~redirect_valid;
    redirect_base = redirect_pc & ALIGN_M;
  end

  // PC tracking and outstanding-request accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_base;
      resp_pc  <= redirect_base;
      live_cnt <= '0;
      // Everything still in flight, plus a request accepted this cycle,
      // becomes stale; any response consumed this cycle leaves the pool.
      drop_cnt <= drop_cnt + live_cnt + CW'(req_fire)
                  - CW'(resp_live) - CW'(resp_drop);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (push) begin
        resp_pc <= resp_pc + PC_STEP;
      end
      live_cnt <= live_cnt + CW'(req_fire) - CW'(resp_live);
      drop_cnt <= drop_cnt - CW'(resp_drop);
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_valid) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: instruction word and the PC it was fetched from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= RESET_PC;
      end
    end else if (push) begin
      buf_data[wr_ptr] <= imem_resp_data;
      buf_pc[wr_ptr]   <= resp_pc;
    end
  end

  // The credit rule must never let a push land in a full FIFO unpopped.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order instruction memory with
// variable latency, a queue-based reference model, directed scenarios
// pinned with literal expectations, and a randomized soak.
module tb_fetch_unit;
  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .opcode(opcode)
  );

  always #5 clk = ~clk;

  // Outstanding requests (memory queue and model view at once).
  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } word_t;
  req_t        oq[$];
  word_t       fq[$];
  logic [31:0] m_fetch_pc;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned resp_pct = 100;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] acc_q[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_data[$];
  int unsigned acc_c[$];
  int unsigned del_c[$];
  logic        last_req_valid;
  logic        last_inst_valid;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idx(input string name, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
    if (idx >= q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: entry %0d missing, expected %h", name, idx, exp);
    end else begin
      chk(name, q[idx], exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); acc_c.delete();
    del_pc.delete(); del_data.delete(); del_c.delete();
  endtask

  // One clock cycle: compare at negedge, advance model, drive memory after edge.
  task automatic step();
    int live;
    int stale;
    bit e_pop;
    bit e_rv;
    bit acc;
    @(negedge clk);
    last_req_valid  = imem_req_valid;
    last_inst_valid = inst_valid;
    last_req_addr   = imem_req_addr;
    if (rst) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, RPC);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_inst_pc", inst_pc, RPC);
      chk("rst_opcode", opcode, 0);
      oq.delete();
      fq.delete();
      m_fetch_pc = RPC;
    end else begin
      live = 0;
      stale = 0;
      foreach (oq[i]) if (oq[i].stale) stale++; else live++;
      e_pop = (fq.size() > 0) && inst_ready;
      e_rv  = ((fq.size() + live - int'(e_pop)) < D) && ((stale + live) < D);
      chk("req_valid", imem_req_valid, e_rv);
      chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("inst_valid", inst_valid, fq.size() > 0);
      if (fq.size() > 0) begin
        chk("inst_pc", inst_pc, fq[0].pc);
        chk("inst_data", inst_data, fq[0].data);
        chk("opcode", opcode, fq[0].data[6:0]);
      end
      if (imem_req_valid && imem_req_ready) begin
        acc_q.push_back(imem_req_addr);
        acc_c.push_back(cyc);
      end
      if (inst_valid && inst_ready) begin
        del_pc.push_back(inst_pc);
        del_data.push_back(inst_data);
        del_c.push_back(cyc);
      end
      acc = e_rv && imem_req_ready;
      if (e_pop) void'(fq.pop_front());
      if (imem_resp_valid && oq.size() > 0) begin
        req_t h = oq.pop_front();
        if (!h.stale && !redirect_valid) fq.push_back('{h.addr, mem_word(h.addr)});
      end
      if (acc) begin
        oq.push_back('{m_fetch_pc, cyc + lat, redirect_valid});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        foreach (oq[i]) oq[i].stale = 1'b1;
        fq.delete();
        m_fetch_pc = redirect_pc & ~32'd3;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    redirect_valid = 1'b0;
    if (oq.size() > 0 && oq[0].due <= cyc && $urandom_range(0, 99) < resp_pct) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(oq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    lat = 1;
    resp_pct = 100;
    repeat (n) step();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_redir;
    logic [31:0] r;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b1;

    // Streaming: one instruction per cycle, 2-cycle fetch-to-decode latency.
    do_reset(3);
    repeat (12) step();
    chk("A_accepts", acc_q.size(), 12);
    chk_idx("A_acc0", acc_q, 0, 32'h0);
    chk_idx("A_acc1", acc_q, 1, 32'h4);
    chk_idx("A_acc2", acc_q, 2, 32'h8);
    chk_idx("A_del0", del_pc, 0, 32'h0);
    chk_idx("A_del1", del_pc, 1, 32'h4);
    chk_idx("A_del2", del_pc, 2, 32'h8);
    if (del_c.size() > 1 && acc_c.size() > 0) begin
      chk("A_latency", del_c[0] - acc_c[0], 2);
      chk("A_rate", del_c[1] - del_c[0], 1);
    end else begin
      chk("A_del_count", del_c.size(), 10);
    end

    // Decode stall: exactly BUF_DEPTH words fetched, then requests stop.
    do_reset(2);
    inst_ready = 1'b0;
    repeat (10) step();
    chk("B_accepts", acc_q.size(), 4);
    chk("B_req_valid", last_req_valid, 0);
    chk("B_inst_valid", last_inst_valid, 1);
    clear_logs();
    inst_ready = 1'b1;
    repeat (8) step();
    chk_idx("B_del0", del_pc, 0, 32'h0);
    chk_idx("B_del1", del_pc, 1, 32'h4);
    chk_idx("B_del2", del_pc, 2, 32'h8);
    chk_idx("B_del3", del_pc, 3, 32'hC);
    chk_idx("B_del4", del_pc, 4, 32'h10);
    chk_idx("B_resume", acc_q, 0, 32'h10);

    // Redirect with two 3-cycle requests in flight.
    do_reset(2);
    lat = 3;
    repeat (2) step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    clear_logs();
    imem_req_ready = 1'b1;
    repeat (12) step();
    chk_idx("C_acc0", acc_q, 0, 32'h100);
    chk_idx("C_del0", del_pc, 0, 32'h100);
    chk_idx("C_data0", del_data, 0, mem_word(32'h100));

    // Redirect coinciding with a response and an accept.
    do_reset(2);
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    step();
    chk("D_req_in_redirect", last_req_valid, 1);
    clear_logs();
    repeat (8) step();
    chk_idx("D_acc0", acc_q, 0, 32'h400);
    chk_idx("D_del0", del_pc, 0, 32'h400);
    chk_idx("D_del1", del_pc, 1, 32'h404);

    // Memory backpressure holds the address; misaligned redirect target.
    do_reset(2);
    imem_req_ready = 1'b0;
    repeat (5) begin
      step();
      chk("E_addr_hold", last_req_addr, 32'h0);
      chk("E_valid_hold", last_req_valid, 1);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step();
    step();
    chk("E_redirect_addr", last_req_addr, 32'h200);
    clear_logs();
    imem_req_ready = 1'b1;
    repeat (6) step();
    chk_idx("E_acc0", acc_q, 0, 32'h200);
    chk_idx("E_del0", del_pc, 0, 32'h200);

    // Reset mid-stream with a full FIFO.
    do_reset(2);
    inst_ready = 1'b0;
    repeat (8) step();
    chk("F_full_valid", last_inst_valid, 1);
    rst = 1'b1;
    step();
    chk("F_rst_inst_valid", last_inst_valid, 0);
    chk("F_rst_addr", last_req_addr, RPC);
    rst = 1'b0;
    clear_logs();
    inst_ready = 1'b1;
    repeat (6) step();
    chk_idx("F_acc0", acc_q, 0, RPC);
    chk_idx("F_del0", del_pc, 0, RPC);
    chk_idx("F_del1", del_pc, 1, RPC + 32'd4);

    // Randomized soak against the model.
    do_reset(2);
    prev_redir = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      imem_req_ready = ($urandom_range(0, 99) < 70);
      inst_ready     = ($urandom_range(0, 99) < 60);
      lat            = $urandom_range(1, 4);
      resp_pct       = 80;
      if ($urandom_range(0, 99) < 4 || (prev_redir && $urandom_range(0, 99) < 30)) begin
        r = $urandom;
        if ($urandom_range(0, 9) == 0) r = 32'hFFFF_FFF0 | {28'h0, r[3:0]};
        redirect_valid = 1'b1;
        redirect_pc = r;
        prev_redir = 1'b1;
      end else begin
        prev_redir = 1'b0;
      end
      rst = ($urandom_range(0, 999) < 3);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage feeding decode: owns the PC, issues word requests to instruction memory over a valid/ready request channel, and accepts in-order responses. Fetched words are held in a small FIFO and presented to decode with a valid/ready handshake. The opcode field is exported directly for the decode control unit. Redirects (branch/jump) flush the FIFO and discard responses still in flight.

Parameters:
XLEN, 32, PC and instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 4, instruction FIFO entries (power of two, >=2); also the maximum number of outstanding requests

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  word address of request (bits [1:0] always 0)
imem_resp_valid  in  1  response data valid; in order, at least 1 cycle after acceptance
imem_resp_data  in  XLEN  fetched instruction word
redirect_valid  in  1  redirect PC (taken branch/jump), single-cycle pulse
redirect_pc  in  XLEN  redirect target
inst_valid  out  1  FIFO head valid to decode
inst_ready  in  1  decode consumes head this cycle
inst_data  out  XLEN  head instruction word
inst_pc  out  XLEN  PC of head instruction
opcode  out  7  inst_data[6:0], to control unit

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, live_cnt=0, drop_cnt=0. Outputs during reset: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=RESET_PC, opcode=0.
- Request issue: imem_req_valid=1 when fifo_count + live_cnt - (inst_valid&inst_ready) < BUF_DEPTH and drop_cnt + live_cnt < BUF_DEPTH. On accept (valid&ready): fetch_pc += 4 (wraps mod 2^XLEN), live_cnt++. imem_req_addr=fetch_pc; it is held stable while valid and not ready.
- Response: while drop_cnt>0, each imem_resp_valid decrements drop_cnt and the data is discarded. Otherwise it is pushed into the FIFO with pc=resp_pc; resp_pc += 4; live_cnt--.
- FIFO: push and pop in the same cycle allowed, including when full (pop frees slot). Credit rule guarantees no overflow; a push into a full FIFO without a pop is an assertion failure. inst_* are registered from FIFO head; a pushed word becomes visible on inst_valid the next cycle (minimum fetch-to-decode latency 2 cycles with 1-cycle memory).
- Steady state: with 1-cycle memory, imem_req_ready=1, inst_ready=1 -> one instruction per cycle after startup.
- Redirect (redirect_valid=1 in cycle N): at edge N, FIFO flushed (inst_valid=0 in N+1), fetch_pc=resp_pc={redirect_pc[XLEN-1:2],2'b00}, drop_cnt += live_cnt (+1 if a request is accepted in N; -1 if a live response arrives in N), live_cnt=0. Request accepted in N carries the old address and is counted stale. Response arriving in N is discarded. Pop in N is honoured (decode owns that word). New-target request may issue in N+1.
- Simultaneous redirect on consecutive cycles: the later one wins; all earlier-path responses are dropped.
- Misaligned redirect_pc: bits [1:0] silently cleared.
- Reset mid-operation: all state cleared immediately; responses to pre-reset requests are the memory's responsibility (memory is reset by the same rst).

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1 -> addresses 0x0,0x4,0x8...; inst_pc 0x0 on inst_valid 2 cycles after first accept, then one per cycle.
- inst_ready=0 for 10 cycles -> exactly BUF_DEPTH (4) words buffered, imem_req_valid=0, no more accepts; release -> 0x0..0xC delivered in order, fetching resumes at 0x10.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc=0x100 -> both stale responses dropped; next inst_valid has inst_pc=0x100, inst_data=mem[0x100].
- Redirect in the same cycle as a response and a request accept -> response discarded, request counted stale, first delivered inst_pc equals redirect target.
- imem_req_ready=0 for 5 cycles -> imem_req_addr held at same value, fetch_pc unchanged; redirect_pc=0x203 -> next request addr 0x200.
- Assert rst for 1 cycle mid-stream with full FIFO -> inst_valid=0 immediately, next request addr RESET_PC, no stale words delivered.
